serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Downstream stage of the bit-serial two's-complement inverter.
- Collects the inverter's LSB-first serial output bit `y` into a parallel WIDTH-bit word.
- Uses a start-of-word marker aligned with the inverter's per-word reset pulse.
- Presents each finished word through a one-entry valid/ready holding register, with sticky overrun and framing-error flags.

Parameters:
- WIDTH, 8, word length in bits (legal range 1..32); bit k of the word is the k-th serial bit received (LSB first).

Ports:
- t_clk  input  1  sole clock, all state updates on rising edge.
- r  input  1  synchronous active-high reset.
- y_in  input  1  serial data bit from the inverter, LSB first.
- bit_valid  input  1  y_in is sampled only on edges where this is 1.
- sof  input  1  start of word, qualified by bit_valid; marks bit 0. Driven by the same pulse as the inverter's r.
- word_out  output  WIDTH  assembled word, valid while word_valid=1.
- word_valid  output  1  holding register full.
- word_ready  input  1  consumer accepts word_out on an edge where word_valid=1 and word_ready=1.
- busy  output  1  1 while in SHIFT state.
- overrun  output  1  sticky: a completed word was dropped.
- sync_err  output  1  sticky: sof arrived mid-word.

Behaviour:
- Reset (r=1 at edge, highest priority):
  - Outputs: word_out=0, word_valid=0, busy=0, overrun=0, sync_err=0.
  - Internal: shift register=0, bit count=0, state=IDLE.
  - Reset mid-word discards the partial word. Reset with word_valid=1 discards the held word.
- IDLE state:
  - bit_valid=1, sof=1: shift[0]<=y_in, count<=1, go to SHIFT.
  - Exception: if WIDTH=1 the word completes immediately (see completion).
  - bit_valid=1 with sof=0: bit ignored, no flag raised.
- SHIFT state:
  - bit_valid=1, sof=0: shift[count]<=y_in, count<=count+1.
  - bit_valid=1, sof=1: partial word discarded, sync_err<=1, y_in taken as new bit 0, count<=1, stay in SHIFT.
  - bit_valid=0: hold all state; gaps of any length are allowed.
- Completion: the edge on which bit index WIDTH-1 is sampled.
  - Full word {y_in, shift[WIDTH-2:0]} is offered to the holding register.
  - count<=0, state<=IDLE.
  - Latency: word_valid=1 in the cycle after that edge (one-edge latency).
- Holding register, evaluated at each edge:
  - Consume: word_valid & word_ready.
  - Load if completion and (!word_valid | consume). Then word_out<=new word, word_valid<=1.
  - Completion with consume on the same edge: back-to-back transfer, word_valid stays 1.
  - Consume without completion: word_valid<=0, word_out holds its last value.
  - Completion with word_valid=1 and word_ready=0: new word dropped, overrun<=1, held word unchanged.
- busy = (state==SHIFT); it is a registered state decode.
- overrun and sync_err clear only via r.
- Counter width is clog2(WIDTH)+1. It never exceeds WIDTH-1 in SHIFT.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Extra output port word_parity (1 bit) = XOR of word_out bits.
  - Registered and loaded on the same edge as word_out; reset value 0.
  - Holds on a drop, exactly like word_out.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic word (WIDTH=8):
  - Stimulus: r for 1 cycle, then sof=1 with the first bit, then the serial bits of 0xB4 (complement of 0x4C), LSB-first: 0,0,1,0,1,1,0,1, with word_ready=1.
  - Response: word_valid pulses 1 cycle, one edge after the 8th bit, with word_out=0xB4. busy=1 for bits 1..7 then 0.
  - With SER_PARITY_EN: word_parity=0.
- Gaps: same word with bit_valid=0 for 3 cycles between bits 3 and 4.
  - Response: word_out=0xB4, no flags set.
- Backpressure/overrun:
  - Stimulus: word_ready=0; send 0x01 then 0xFF.
  - Response: word_out stays 0x01, word_valid=1, overrun=1 after the 8th bit of 0xFF. Raising word_ready then clears word_valid.
- Back-to-back:
  - Stimulus: word_ready asserted exactly on the completion edge of the second word 0x80 while 0x7F is held.
  - Response: 0x7F consumed, word_out=0x80, word_valid stays 1, overrun=0.
- Framing error:
  - Stimulus: sof after 5 bits, followed by 8 bits of 0x3C.
  - Response: sync_err=1, word_out=0x3C, no partial word ever emitted.
- Reset mid-word:
  - Stimulus: r=1 after 4 bits with a held word present.
  - Response: next edge word_valid=0, word_out=0, busy=0, flags 0. A subsequent clean 0xA5 is received correctly.

Source files
------------

// File: rtl/serial_word_collector.sv
// serial_word_collector
// Collects an LSB-first serial bit stream into WIDTH-bit words and hands each
// finished word over through a one-entry valid/ready holding register.
// Sticky flags: overrun (finished word dropped), sync_err (sof mid-word).
// Optional: define SER_PARITY_EN to add the registered word_parity output.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             y_in,
    input  logic             bit_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
`ifdef SER_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;
    logic             r_sync_err;

    logic             w_take;
    logic [CW-1:0]    w_idx;
    logic             w_complete;
    logic [WIDTH-1:0] w_new_word;
    logic             w_consume;
    logic             w_load;

    // Decode which bit position this edge writes and whether it ends the word
    always_comb begin
        w_take     = bit_valid & (sof | (r_state == SHIFT));
        w_idx      = sof ? '0 : r_count;
        w_complete = w_take & (w_idx == CW'(WIDTH - 1));
        w_new_word = r_shift;
        w_new_word[w_idx] = y_in;
        w_consume  = r_valid & word_ready;
        w_load     = w_complete & (~r_valid | w_consume);
    end

    // Collector FSM, holding register and sticky flags
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_take) begin
                r_shift <= w_new_word;
                if (sof && (r_state == SHIFT))
                    r_sync_err <= 1'b1;
                if (w_complete) begin
                    r_count <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_count <= w_idx + CW'(1);
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                end
            end

            if (w_load) begin
                r_word  <= w_new_word;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SER_PARITY_EN
    logic r_parity;

    // Parity follows word_out: loaded on the same edge, held on a drop
    always_ff @(posedge t_clk) begin
        if (r)
            r_parity <= 1'b0;
        else if (w_load)
            r_parity <= ^w_new_word;
    end

    assign word_parity = r_parity;
`endif

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_serial_word_collector.sv
// Testbench for serial_word_collector (WIDTH=8): directed scenarios plus a
// randomized run, all compared against a word-level reference model.
module tb_serial_word_collector;

    localparam int WIDTH = 8;

    logic             t_clk = 1'b0;
    logic             r = 1'b1;
    logic             y_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             sof = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic             overrun;
    logic             sync_err;
`ifdef SER_PARITY_EN
    logic             word_parity;
`endif

    int errors = 0;
    int checks = 0;

    serial_word_collector #(.WIDTH(WIDTH)) dut (
        .t_clk      (t_clk),
        .r          (r),
        .y_in       (y_in),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun),
        .sync_err   (sync_err)
`ifdef SER_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    always #5 t_clk = ~t_clk;

    // Reference model: word in progress kept as a bit count and an integer value
    bit          m_in_word;
    int          m_n;
    int unsigned m_acc;
    int unsigned m_word;
    bit          m_valid;
    bit          m_over;
    bit          m_sync;

    task automatic model_edge(input logic rr, input logic bv, input logic sf,
                              input logic yy, input logic rdy);
        bit done;
        bit consume;
        done    = 1'b0;
        consume = m_valid && rdy;
        if (rr) begin
            m_in_word = 0; m_n = 0; m_acc = 0; m_word = 0;
            m_valid = 0; m_over = 0; m_sync = 0;
        end else begin
            if (bv && (sf || m_in_word)) begin
                if (sf) begin
                    if (m_in_word) m_sync = 1;
                    m_acc = yy;
                    m_n   = 1;
                end else begin
                    m_acc = m_acc + (int'(yy) << m_n);
                    m_n   = m_n + 1;
                end
                if (m_n == WIDTH) begin
                    done      = 1'b1;
                    m_in_word = 0;
                    m_n       = 0;
                end else begin
                    m_in_word = 1;
                end
            end
            if (done && (!m_valid || consume)) begin
                m_word  = m_acc;
                m_valid = 1;
            end else if (done) begin
                m_over = 1;
            end else if (consume) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: apply inputs, advance the model, settle just after the edge
    task automatic cyc(input logic rr, input logic bv, input logic sf,
                       input logic yy, input logic rdy);
        r = rr; bit_valid = bv; sof = sf; y_in = yy; word_ready = rdy;
        @(posedge t_clk);
        model_edge(rr, bv, sf, yy, rdy);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, i == 0, w[i], (i == 7) ? rdy_last : rdy);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (word_out !== 8'h00 || word_valid !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%h v=%b busy=%b ovr=%b serr=%b, expected all 0",
                     word_out, word_valid, busy, overrun, sync_err);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hB4;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, i == 0, w[i], 1'b1);
            checks++;
            if (busy !== (i < 7) || word_valid !== (i == 7)) begin
                errors++;
                $display("FAIL basic_bit%0d: busy=%b valid=%b, expected busy=%b valid=%b",
                         i, busy, word_valid, i < 7, i == 7);
            end
        end
        checks++;
        if (word_out !== 8'hB4) begin
            errors++;
            $display("FAIL basic_word: got %h expected b4", word_out);
        end
`ifdef SER_PARITY_EN
        checks++;
        if (word_parity !== 1'b0) begin
            errors++;
            $display("FAIL basic_parity: got %b expected 0", word_parity);
        end
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 8'hB4) begin
            errors++;
            $display("FAIL basic_pulse: valid=%b out=%h expected valid=0 out=b4", word_valid, word_out);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'hB4;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4)
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                    checks++;
                    if (busy !== 1'b1 || word_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps_hold: busy=%b valid=%b expected busy=1 valid=0", busy, word_valid);
                    end
                end
            cyc(1'b0, 1'b1, i == 0, w[i], 1'b1);
        end
        checks++;
        if (word_out !== 8'hB4 || word_valid !== 1'b1 || overrun !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_word: out=%h v=%b ovr=%b serr=%b expected b4 1 0 0",
                     word_out, word_valid, overrun, sync_err);
        end
    endtask

    task automatic test_overrun();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h01, 1'b0, 1'b0);
        checks++;
        if (word_out !== 8'h01 || word_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: out=%h v=%b ovr=%b expected 01 1 0", word_out, word_valid, overrun);
        end
        send_word(8'hFF, 1'b0, 1'b0);
        checks++;
        if (word_out !== 8'h01 || word_valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: out=%h v=%b ovr=%b expected 01 1 1", word_out, word_valid, overrun);
        end
`ifdef SER_PARITY_EN
        checks++;
        if (word_parity !== 1'b1) begin
            errors++;
            $display("FAIL ovr_parity: got %b expected 1", word_parity);
        end
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 8'h01 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drain: v=%b out=%h ovr=%b expected 0 01 1", word_valid, word_out, overrun);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h7F, 1'b0, 1'b0);
        send_word(8'h80, 1'b0, 1'b1);
        checks++;
        if (word_out !== 8'h80 || word_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b: out=%h v=%b ovr=%b expected 80 1 0", word_out, word_valid, overrun);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_framing();
        logic [4:0] junk;
        junk = 5'b10111;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, i == 0, junk[i], 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, i == 0, i >= 2 && i <= 5, 1'b1);
            if (i < 7) begin
                checks++;
                if (word_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_partial: valid=%b at bit %0d expected 0", word_valid, i);
                end
            end
        end
        checks++;
        if (sync_err !== 1'b1 || word_out !== 8'h3C || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_word: serr=%b out=%h v=%b expected 1 3c 1", sync_err, word_out, word_valid);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, i == 0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 8'h00 || busy !== 1'b0 ||
            overrun !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid: v=%b out=%h busy=%b ovr=%b serr=%b expected all 0",
                     word_valid, word_out, busy, overrun, sync_err);
        end
        send_word(8'hA5, 1'b1, 1'b1);
        checks++;
        if (word_out !== 8'hA5 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: out=%h v=%b expected a5 1", word_out, word_valid);
        end
    endtask

    task automatic test_random();
        logic rr, bv, sf, yy, rdy;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            rr  = ($urandom_range(0, 299) == 0);
            bv  = ($urandom_range(0, 3) != 0);
            sf  = ($urandom_range(0, 11) == 0);
            yy  = $urandom_range(0, 1);
            rdy = ($urandom_range(0, 2) != 0);
            cyc(rr, bv, sf, yy, rdy);
            checks++;
            if (word_valid !== m_valid || word_out !== m_word[7:0] || busy !== m_in_word ||
                overrun !== m_over || sync_err !== m_sync) begin
                errors++;
                $display("FAIL random cyc%0d: got v=%b out=%h busy=%b ovr=%b serr=%b, model v=%b out=%h busy=%b ovr=%b serr=%b",
                         n, word_valid, word_out, busy, overrun, sync_err,
                         m_valid, m_word[7:0], m_in_word, m_over, m_sync);
            end
`ifdef SER_PARITY_EN
            checks++;
            if (word_parity !== ($countones(m_word) % 2 == 1)) begin
                errors++;
                $display("FAIL random_parity cyc%0d: got %b", n, word_parity);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
